// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and constants for the traffic phase sequencer.
// Phase encodings, {R,Y,G} lamp codes and default phase durations.
package traffic_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_MAIN_GREEN_SEC = 10;
    localparam int DEF_SIDE_GREEN_SEC = 6;
    localparam int DEF_YELLOW_SEC     = 3;
    localparam int DEF_ALL_RED_SEC    = 1;
    localparam int DEF_TIMER_W        = 6;

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Phase duration timer: loaded on phase entry, counts sec_tick down.
// Ports: clk, reset, load, load_val, tick in; expired out (sticky + same-cycle).
module phase_timer
    import traffic_phase_sequencer_pkg::*;
#(
    parameter int TIMER_W   = DEF_TIMER_W,
    parameter int RESET_VAL = DEF_MAIN_GREEN_SEC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               expired
);

    logic [TIMER_W-1:0] count;
    logic               done_q;
    logic               hit;

    // The last tick of a phase expires it in the same cycle, so the
    // owner can transition on that very tick.
    assign hit     = tick && (count == TIMER_W'(1));
    assign expired = done_q | hit;

    // Load wins over tick: a tick in the entry cycle is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= TIMER_W'(RESET_VAL);
            done_q <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            done_q <= 1'b0;
        end else if (hit) begin
            done_q <= 1'b1;
        end else if (tick && count > TIMER_W'(1)) begin
            count  <= count - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection sequencer with side-road pedestrian crossing.
// In: clk, reset, sec_tick, side_request, ped_request.
// Out: main_light, side_light, ped_walk, divider_reset, phase.
module traffic_phase_sequencer
    import traffic_phase_sequencer_pkg::*;
#(
    parameter int MAIN_GREEN_SEC = DEF_MAIN_GREEN_SEC,
    parameter int SIDE_GREEN_SEC = DEF_SIDE_GREEN_SEC,
    parameter int YELLOW_SEC     = DEF_YELLOW_SEC,
    parameter int ALL_RED_SEC    = DEF_ALL_RED_SEC,
    parameter int TIMER_W        = DEF_TIMER_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       side_request,
    input  logic       ped_request,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic       divider_reset,
    output logic [2:0] phase
);

    phase_e             state_q, state_d;
    logic               expired;
    logic               load;
    logic [TIMER_W-1:0] load_val;
    logic               ped_pending_q;
    logic               pend_eff;
    logic [2:0]         main_d, side_d;
    logic               walk_d, pend_d;

    // A press in the current cycle counts as already pending.
    assign pend_eff = ped_pending_q | ped_request;
    assign load     = (state_d != state_q);
    assign phase    = state_q;

    phase_timer #(
        .TIMER_W   (TIMER_W),
        .RESET_VAL (MAIN_GREEN_SEC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (sec_tick),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= MAIN_GREEN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MAIN_GREEN:
                if (expired && (side_request || pend_eff))
                    state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expired) state_d = ALL_RED_A;
            ALL_RED_A:   if (expired) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (expired) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (expired) state_d = ALL_RED_B;
            ALL_RED_B:   if (expired) state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase
    end

    always_comb begin
        load_val = TIMER_W'(MAIN_GREEN_SEC);
        main_d   = LAMP_RED;
        side_d   = LAMP_RED;
        unique case (state_d)
            MAIN_GREEN: begin
                load_val = TIMER_W'(MAIN_GREEN_SEC);
                main_d   = LAMP_GRN;
            end
            MAIN_YELLOW: begin
                load_val = TIMER_W'(YELLOW_SEC);
                main_d   = LAMP_YEL;
            end
            SIDE_GREEN: begin
                load_val = TIMER_W'(SIDE_GREEN_SEC);
                side_d   = LAMP_GRN;
            end
            SIDE_YELLOW: begin
                load_val = TIMER_W'(YELLOW_SEC);
                side_d   = LAMP_YEL;
            end
            default: load_val = TIMER_W'(ALL_RED_SEC);
        endcase
        // Walk is decided once, at side-green entry, then held.
        walk_d = (state_d == SIDE_GREEN) && (load ? pend_eff : ped_walk);
        pend_d = (load && state_d == SIDE_GREEN) ? 1'b0 : pend_eff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_light    <= LAMP_GRN;
            side_light    <= LAMP_RED;
            ped_walk      <= 1'b0;
            ped_pending_q <= 1'b0;
            divider_reset <= 1'b1;
        end else begin
            main_light    <= main_d;
            side_light    <= side_d;
            ped_walk      <= walk_d;
            ped_pending_q <= pend_d;
            divider_reset <= load;
        end
    end

endmodule
